// File: rtl/paddle_input.sv
// Up/down button front end for the paddle: synchronize, debounce, decode, step with optional auto-repeat.
// Optional feature macro: PADDLE_AUTOREPEAT_EN (REPEAT state plus repeat timer).
module paddle_input #(
  parameter int unsigned HEIGHT          = 9,
  parameter int unsigned PADDLE_LEN      = 3,
  parameter int unsigned START_Y         = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned REPEAT_DELAY    = 3000000,
  parameter int unsigned REPEAT_RATE     = 1200000
) (
  input  logic       p_clk12,
  input  logic       p_rst,
  input  logic       p_upBtn,
  input  logic       p_dwnBtn,
  output logic [3:0] paddle_y,
  output logic       paddle_move,
  output logic       paddle_dir
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned MaxY = HEIGHT + 1 - PADDLE_LEN;

  if (PADDLE_LEN < 1 || PADDLE_LEN > HEIGHT + 1 || HEIGHT > 15 || START_Y > MaxY ||
      DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_badParams
    $error("paddle_input: invalid parameter set");
  end

  typedef enum logic [1:0] {CMD_NONE, CMD_UP, CMD_DOWN} cmd_t;

`ifdef PADDLE_AUTOREPEAT_EN
  localparam int unsigned TmrMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  logic [TmrW-1:0] timer, timerNext;
`else
  typedef enum logic [0:0] {IDLE, HOLD} state_t;
`endif

  // Bit 0 is the up button, bit 1 the down button; both active-low.
  logic [1:0]      sync1, sync2, debBtn;
  logic [DebW-1:0] debCnt [2];
  state_t          state, stateNext;
  cmd_t            heldCmd, heldNext, cmdC;
  logic            stepC;

  // Two-flop synchronizer and per-button debounce counters.
  always_ff @(posedge p_clk12) begin
    if (p_rst) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      debBtn <= 2'b11;
      for (int i = 0; i < 2; i++) debCnt[i] <= '0;
    end else begin
      sync1 <= {p_dwnBtn, p_upBtn};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == debBtn[i]) begin
          debCnt[i] <= '0;
        end else if (debCnt[i] == DebW'(DEBOUNCE_CYCLES - 1)) begin
          debBtn[i] <= sync2[i];
          debCnt[i] <= '0;
        end else begin
          debCnt[i] <= debCnt[i] + DebW'(1);
        end
      end
    end
  end

  always_comb begin
    cmdC = CMD_NONE;
    if (!debBtn[0] && debBtn[1])      cmdC = CMD_UP;
    else if (debBtn[0] && !debBtn[1]) cmdC = CMD_DOWN;
  end

  // Next state, step request and timer control.
  always_comb begin
    stateNext = state;
    heldNext  = heldCmd;
    stepC     = 1'b0;
`ifdef PADDLE_AUTOREPEAT_EN
    timerNext = timer + TmrW'(1);
`endif
    case (state)
      IDLE: begin
        if (cmdC != CMD_NONE) begin
          stateNext = HOLD;
          heldNext  = cmdC;
          stepC     = 1'b1;
        end
      end
      default: begin
        if (cmdC == CMD_NONE) begin
          stateNext = IDLE;
          heldNext  = CMD_NONE;
        end else if (cmdC != heldCmd) begin
          stateNext = HOLD;
          heldNext  = cmdC;
          stepC     = 1'b1;
`ifdef PADDLE_AUTOREPEAT_EN
        end else if (state == HOLD && timer == TmrW'(REPEAT_DELAY - 1)) begin
          stateNext = REPEAT;
          stepC     = 1'b1;
        end else if (state == REPEAT && timer == TmrW'(REPEAT_RATE - 1)) begin
          stepC     = 1'b1;
`endif
        end
      end
    endcase
`ifdef PADDLE_AUTOREPEAT_EN
    if (state == IDLE || stateNext != state || stepC) timerNext = '0;
`endif
  end

  always_ff @(posedge p_clk12) begin
    if (p_rst) begin
      state   <= IDLE;
      heldCmd <= CMD_NONE;
`ifdef PADDLE_AUTOREPEAT_EN
      timer   <= '0;
`endif
    end else begin
      state   <= stateNext;
      heldCmd <= heldNext;
`ifdef PADDLE_AUTOREPEAT_EN
      timer   <= timerNext;
`endif
    end
  end

  // Paddle position; a step at a limit is swallowed without a pulse.
  always_ff @(posedge p_clk12) begin
    if (p_rst) begin
      paddle_y    <= 4'(START_Y);
      paddle_move <= 1'b0;
      paddle_dir  <= 1'b0;
    end else begin
      paddle_move <= 1'b0;
      if (stepC) begin
        if (cmdC == CMD_UP && paddle_y < 4'(MaxY)) begin
          paddle_y    <= paddle_y + 4'd1;
          paddle_move <= 1'b1;
          paddle_dir  <= 1'b1;
        end else if (cmdC == CMD_DOWN && paddle_y != 4'd0) begin
          paddle_y    <= paddle_y - 4'd1;
          paddle_move <= 1'b1;
          paddle_dir  <= 1'b0;
        end
      end
    end
  end

endmodule
